// File: rtl/multi_tick_gen_if.sv
// Control and status bundle for multi_tick_gen: shared enable/restart,
// packed per-channel limits and mode selects in, tick strobes and outputs back.
interface multi_tick_gen_if #(
    parameter int CHANNELS = 4,
    parameter int BITLEN   = 8
);
    logic                       en;
    logic                       restart;
    logic [CHANNELS*BITLEN-1:0] lim;
    logic [CHANNELS-1:0]        mode;
    logic [CHANNELS-1:0]        tick;
    logic [CHANNELS-1:0]        out;

    modport master (
        output en,
        output restart,
        output lim,
        output mode,
        input  tick,
        input  out
    );

    modport slave (
        input  en,
        input  restart,
        input  lim,
        input  mode,
        output tick,
        output out
    );
endinterface

// File: rtl/multi_tick_gen.sv
// Bank of independent programmable clock dividers. Each channel emits a
// one-cycle tick per wrap and a 50% square wave, selectable per channel.
module multi_tick_gen #(
    parameter int CHANNELS = 4,
    parameter int BITLEN   = 8
) (
    input  logic            clk,
    input  logic            rst,
    multi_tick_gen_if.slave bus
);

    logic [CHANNELS-1:0][BITLEN-1:0] cnt_q, cnt_d;
    logic [CHANNELS-1:0][BITLEN-1:0] lim_q, lim_d;
    logic [CHANNELS-1:0]             tick_q, tick_d;
    logic [CHANNELS-1:0]             tog_q, tog_d;

    // The active limit is only sampled on a wrap or restart, so a limit
    // change never disturbs the period already in progress.
    always_comb begin
        cnt_d  = cnt_q;
        lim_d  = lim_q;
        tog_d  = tog_q;
        tick_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.restart) begin
                cnt_d[i] = '0;
                lim_d[i] = bus.lim[i*BITLEN +: BITLEN];
                tog_d[i] = 1'b0;
            end else if (bus.en) begin
                if (cnt_q[i] == lim_q[i]) begin
                    cnt_d[i]  = '0;
                    lim_d[i]  = bus.lim[i*BITLEN +: BITLEN];
                    tick_d[i] = 1'b1;
                    tog_d[i]  = ~tog_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + BITLEN'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            lim_q  <= '0;
            tick_q <= '0;
            tog_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            lim_q  <= lim_d;
            tick_q <= tick_d;
            tog_q  <= tog_d;
        end
    end

    assign bus.tick = tick_q;
    assign bus.out  = (bus.mode & tick_q) | (~bus.mode & tog_q);

endmodule

// File: tb/tb_multi_tick_gen.sv
// Directed bench for multi_tick_gen: a remaining-cycles model pushes expected
// tick/out per clock into a scoreboard that is popped on the falling edge.
module tb_multi_tick_gen;

    localparam int CH = 4;
    localparam int BL = 8;

    localparam logic [CH*BL-1:0] LIMS_A = {8'd5, 8'd2, 8'd0, 8'd3};
    localparam logic [CH*BL-1:0] LIMS_B = {8'd5, 8'd2, 8'd0, 8'd9};
    localparam logic [CH*BL-1:0] LIMS_C = {8'd255, 8'd7, 8'd5, 8'd2};
    localparam logic [CH*BL-1:0] LIMS_D = {8'd255, 8'd7, 8'd5, 8'd3};

    typedef struct packed {
        logic [CH-1:0] tick;
        logic [CH-1:0] out;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multi_tick_gen_if #(.CHANNELS(CH), .BITLEN(BL)) bus ();

    multi_tick_gen #(.CHANNELS(CH), .BITLEN(BL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            n_checks = 0;
    int            n_fails  = 0;
    int            cyc      = 0;
    int            m_rem [CH];
    logic [CH-1:0] m_tick;
    logic [CH-1:0] m_tog;
    exp_t          sb [$];
    int            tick0_times [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic e, input logic r,
                                  input logic [CH*BL-1:0] l, input logic [CH-1:0] m);
        bus.en      = e;
        bus.restart = r;
        bus.lim     = l;
        bus.mode    = m;
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) m_rem[i] = 0;
        m_tick = '0;
        m_tog  = '0;
    endtask

    // Model tracks cycles left until the next wrap rather than a counter.
    task automatic model_step();
        if (!rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (bus.restart) begin
                    m_rem[i]  = int'(bus.lim[i*BL +: BL]);
                    m_tick[i] = 1'b0;
                    m_tog[i]  = 1'b0;
                end else if (bus.en && m_rem[i] == 0) begin
                    m_rem[i]  = int'(bus.lim[i*BL +: BL]);
                    m_tick[i] = 1'b1;
                    m_tog[i]  = ~m_tog[i];
                end else begin
                    if (bus.en) m_rem[i] = m_rem[i] - 1;
                    m_tick[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_output(input string tag);
        exp_t e;
        e = sb.pop_front();
        check({tag, "_tick"}, 32'(bus.tick), 32'(e.tick));
        check({tag, "_out"}, 32'(bus.out), 32'(e.out));
    endtask

    task automatic cycle(input string tag);
        exp_t e;
        @(posedge clk);
        model_step();
        e.tick = m_tick;
        e.out  = (bus.mode & m_tick) | (~bus.mode & m_tog);
        sb.push_back(e);
        @(negedge clk);
        cyc++;
        check_output(tag);
        if (bus.tick[0]) tick0_times.push_back(cyc);
    endtask

    task automatic run(input int n, input string tag);
        for (int k = 0; k < n; k++) cycle(tag);
    endtask

    task automatic wait_tick0(input string tag);
        logic found;
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
            cycle(tag);
            if (bus.tick[0]) found = 1'b1;
        end
        check({tag, "_found"}, 32'(found), 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        apply_stimulus(1'b0, 1'b0, '0, '0);
        model_reset();
        #1;
        check("reset_tick", 32'(bus.tick), 32'd0);
        check("reset_out", 32'(bus.out), 32'd0);
        run(2, "in_reset");

        // First enabled cycle after reset wraps every channel.
        rst = 1'b1;
        apply_stimulus(1'b1, 1'b0, LIMS_A, 4'b0010);
        cycle("first_wrap");
        check("first_wrap_all", 32'(bus.tick), 32'hF);

        apply_stimulus(1'b0, 1'b1, LIMS_A, 4'b0010);
        cycle("restart");
        check("restart_tick", 32'(bus.tick), 32'd0);
        check("restart_out", 32'(bus.out), 32'd0);

        apply_stimulus(1'b1, 1'b0, LIMS_A, 4'b0010);
        tick0_times.delete();
        run(24, "lim3");
        check("lim3_count", 32'(tick0_times.size()), 32'd6);
        for (int k = 0; k < 5; k++)
            check("lim3_period", 32'(tick0_times[k+1] - tick0_times[k]), 32'd4);
        check("ch1_pulse_out", 32'(bus.out[1]), 32'd1);

        // Limit raised one cycle into a period: old period finishes first.
        wait_tick0("sync");
        tick0_times.delete();
        tick0_times.push_back(cyc);
        cycle("q0_is_1");
        apply_stimulus(1'b1, 1'b0, LIMS_B, 4'b0010);
        run(30, "lim9");
        check("lim_change_first", 32'(tick0_times[1] - tick0_times[0]), 32'd4);
        check("lim_change_second", 32'(tick0_times[2] - tick0_times[1]), 32'd10);
        check("lim_change_third", 32'(tick0_times[3] - tick0_times[2]), 32'd10);

        apply_stimulus(1'b0, 1'b0, LIMS_B, 4'b0010);
        run(5, "en_low");
        check("en_low_tick", 32'(bus.tick), 32'd0);
        apply_stimulus(1'b1, 1'b0, LIMS_B, 4'b0010);
        run(12, "en_resume");

        apply_stimulus(1'b1, 1'b0, LIMS_B, 4'b0011);
        #1;
        check("mode_switch_out", 32'(bus.out), 32'((bus.mode & m_tick) | (~bus.mode & m_tog)));
        run(6, "mode_pulse0");
        apply_stimulus(1'b1, 1'b0, LIMS_B, 4'b0000);
        #1;
        check("mode_back_out", 32'(bus.out), 32'((bus.mode & m_tick) | (~bus.mode & m_tog)));
        run(4, "mode_toggle");

        apply_stimulus(1'b1, 1'b1, LIMS_C, 4'b0000);
        cycle("restart_align");
        check("restart_align_out", 32'(bus.out), 32'd0);
        apply_stimulus(1'b1, 1'b0, LIMS_C, 4'b0000);
        run(520, "aligned");

        // Restart lands exactly on a wrap cycle for channel 0.
        apply_stimulus(1'b1, 1'b0, LIMS_D, 4'b0000);
        wait_tick0("pre_wrap");
        run(3, "to_limit");
        apply_stimulus(1'b1, 1'b1, LIMS_D, 4'b0000);
        cycle("restart_at_wrap");
        check("restart_wins_tick", 32'(bus.tick[0]), 32'd0);
        check("restart_wins_out", 32'(bus.out[0]), 32'd0);

        apply_stimulus(1'b1, 1'b0, LIMS_A, 4'b0010);
        run(5, "pre_async");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_tick", 32'(bus.tick), 32'd0);
        check("async_out", 32'(bus.out), 32'd0);
        run(2, "held_reset");
        rst = 1'b1;
        cycle("post_reset_wrap");
        check("post_reset_all", 32'(bus.tick), 32'hF);
        run(20, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/multi_tick_gen.md
MULTI_TICK_GEN -- requirements
Module: multi_tick_gen

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4: number of independent divider channels (1..16).
REQ-002 The block SHALL have parameter BITLEN, default 8: counter and limit width per channel.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset; port list as follows (clock and reset first).
REQ-004 clk  input  1  rising-edge system clock; the only clock in the block.
REQ-005 rst  input  1  asynchronous active-low reset (0 = reset).
REQ-006 en  input  1  global count enable; 1 = all channels count.
REQ-007 restart  input  1  synchronous realign: clears all channels and reloads limits.
REQ-008 lim  input  CHANNELS*BITLEN  packed limits; channel i uses lim[i*BITLEN +: BITLEN].
REQ-009 mode  input  CHANNELS  per channel output select: 0 = toggle (square wave), 1 = pulse.
REQ-010 tick  output  CHANNELS  registered one-cycle strobe per channel wrap.
REQ-011 out  output  CHANNELS  per channel mode-selected output.

Function
REQ-012 Each channel i SHALL hold a BITLEN-bit counter Q_i, a BITLEN-bit active limit L_i, a tick register and a toggle register.
REQ-013 All outputs SHALL be clock-synchronous data signals; no output or internal signal SHALL be used as a clock.
REQ-014 Wrap condition: en=1, restart=0 and Q_i == L_i.
REQ-015 On a wrap, Q_i SHALL go to 0 and L_i SHALL load lim_i; otherwise with en=1 Q_i SHALL increment by 1.
REQ-016 A lim_i change mid-period SHALL NOT affect the period in progress; it takes effect from the next wrap.
REQ-017 tick_i SHALL be 1 in the cycle after a wrap and 0 in all other cycles; tick period = L_i+1 cycles.
REQ-018 The toggle register of channel i SHALL invert on every wrap; toggle period = 2*(L_i+1) cycles, 50% duty.
REQ-019 out_i SHALL equal tick_i when mode_i=1 and the toggle register when mode_i=0; a mode change SHALL take effect in the same cycle.
REQ-020 lim_i = 0 SHALL produce tick_i = 1 on every enabled cycle and toggle inversion every enabled cycle.
REQ-021 lim_i = all-ones SHALL give period 2^BITLEN with no overflow beyond BITLEN bits.
REQ-022 With en=0 and restart=0: Q, L and toggle SHALL hold; tick SHALL be 0 in the following cycle.
REQ-023 restart=1 SHALL take priority over en: every Q_i <= 0, L_i <= lim_i, tick <= 0, toggle <= 0, in one cycle.
REQ-024 Channels SHALL be fully independent apart from the shared en and restart inputs.

Reset
REQ-025 While rst=0, every Q_i, L_i, tick and toggle register SHALL be 0 immediately, independent of clk.
REQ-026 Immediately after reset, out SHALL be 0 and tick SHALL be 0.
REQ-027 With L_i=0 after reset, the first enabled cycle SHALL be a wrap that loads lim_i.
REQ-028 Reset deassertion SHALL be honoured on the next rising clk edge; reset asserted mid-period SHALL abandon the period with no extra tick.

Verification
REQ-029 Scenario: reset, restart pulse, lim_0=3, en=1 -> tick_0 every 4 cycles; mode_0=0 -> out_0 period 8, 4 high / 4 low.
REQ-030 Scenario: lim_0=3 counting, set lim_0=9 when Q_0=1 -> the next tick still comes 4 cycles after the previous one; later ticks are 10 cycles apart.
REQ-031 Scenario: lim_1=0, mode_1=1 -> out_1 = 1 every enabled cycle; drop en for 5 cycles -> tick_1=0 and Q frozen; re-raise -> resumes without phase loss.
REQ-032 Scenario: channels with lims 2,5,7,255 running, restart pulse -> all Q=0 and toggles=0 next cycle; ticks then occur at 3,6,8,256-cycle periods, phase-aligned.
REQ-033 Scenario: en=1 and restart=1 together with Q_0==L_0 -> restart wins, tick_0=0, toggle_0=0 next cycle.
REQ-034 Scenario: assert rst=0 between clock edges mid-period -> all outputs 0 immediately; after release, behaviour per REQ-027.
